// File: rtl/nav_pkg.sv
// Shared navigation types: polar location packing {theta, r}, the waypoint
// table reset image, and the sequencer state encoding.
package nav_pkg;

   localparam int THETA_W           = 5;
   localparam int R_W               = 7;
   localparam int LOC_W             = THETA_W + R_W;
   localparam int DEG_PER_THETA_LSB = 15;

   localparam logic [LOC_W-1:0] DEFAULT_LOCATION = {5'd6, 7'd24};
   localparam logic [LOC_W-1:0] RST_ENTRY1       = {5'd1, 7'd32};
   localparam logic [LOC_W-1:0] RST_ENTRY2       = {5'd7, 7'd48};
   localparam logic [LOC_W-1:0] RST_ENTRY3       = {5'd8, 7'd10};
   localparam logic [LOC_W-1:0] RST_ENTRY4       = {5'd11, 7'd80};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_e;

   // Entries beyond the preloaded route fall back to the home location.
   function automatic logic [LOC_W-1:0] reset_entry(input int idx);
      case (idx)
         1:       return RST_ENTRY1;
         2:       return RST_ENTRY2;
         3:       return RST_ENTRY3;
         4:       return RST_ENTRY4;
         default: return DEFAULT_LOCATION;
      endcase
   endfunction

endpackage

// File: rtl/waypoint_table.sv
// DEPTH x LOC_W waypoint register file with a reset image, one write port and
// a combinational read port that forwards same-cycle write data.
module waypoint_table
   import nav_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [LOC_W-1:0]  wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [LOC_W-1:0]  rd_data_o
);

   logic [LOC_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= reset_entry(i);
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Forwarding lets an edit to the upcoming index land on location one cycle later.
   assign rd_data_o = (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];

endmodule

// File: rtl/target_waypoint_sequencer.sv
// Drives the rover's current polar target: either a manually selected table
// entry or a route through entries 0..len-1 advanced by arrival pulses.
module target_waypoint_sequencer
   import nav_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              mode,
   input  logic [ADDR_W-1:0] sel,
   input  logic [ADDR_W:0]   route_len,
   input  logic              start,
   input  logic              arrived,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [LOC_W-1:0]  wr_data,
   output logic [LOC_W-1:0]  location,
   output logic              new_target,
   output logic [ADDR_W-1:0] cur_index,
   output logic              busy,
   output logic              route_done
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   seq_state_e        state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [LOC_W-1:0]  loc_q, loc_d;
   logic              new_target_q, busy_q, done_q;
   logic              load;
   logic [LOC_W-1:0]  rd_data;

   waypoint_table #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_table (
      .clock_i   (clock),
      .reset_n_i (reset_n),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_addr_i (idx_d),
      .rd_data_o (rd_data)
   );

   // The table is read at the index that will drive location after this edge.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      load    = 1'b1;
      if (!mode) begin
         state_d = IDLE;
         idx_d   = sel;
      end else begin
         case (state_q)
            RUN: begin
               if (arrived) begin
                  if ({1'b0, idx_q} == len_q - 1'b1) state_d = DONE;
                  else                               idx_d   = idx_q + 1'b1;
               end
            end
            default: begin
               if (start && (route_len != '0)) begin
                  len_d   = (route_len > DEPTH_L) ? DEPTH_L : route_len;
                  idx_d   = '0;
                  state_d = RUN;
               end else if (state_q == IDLE) begin
                  load = 1'b0;
               end
            end
         endcase
      end
      loc_d = load ? rd_data : loc_q;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         len_q        <= '0;
         idx_q        <= '0;
         loc_q        <= DEFAULT_LOCATION;
         new_target_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         loc_q        <= loc_d;
         new_target_q <= (loc_d != loc_q);
         busy_q       <= (state_d == RUN);
         done_q       <= (state_d == DONE);
      end
   end

   assign location   = loc_q;
   assign new_target = new_target_q;
   assign cur_index  = idx_q;
   assign busy       = busy_q;
   assign route_done = done_q;

endmodule

// File: tb/tb_target_waypoint_sequencer.sv
// Directed and randomized checks of the waypoint sequencer against a
// table/route reference model kept in the bench.
module tb_target_waypoint_sequencer;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        mode = 1'b0;
   logic [2:0]  sel = '0;
   logic [3:0]  route_len = '0;
   logic        start = 1'b0;
   logic        arrived = 1'b0;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_addr = '0;
   logic [11:0] wr_data = '0;
   logic [11:0] location;
   logic        new_target;
   logic [2:0]  cur_index;
   logic        busy;
   logic        route_done;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: table contents, route progress, expected outputs.
   logic [11:0] m_tbl [8];
   logic [11:0] m_loc;
   int          m_idx, m_len;
   bit          m_run, m_done, m_nt;

   always #5 clock = ~clock;

   target_waypoint_sequencer dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .mode       (mode),
      .sel        (sel),
      .route_len  (route_len),
      .start      (start),
      .arrived    (arrived),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .location   (location),
      .new_target (new_target),
      .cur_index  (cur_index),
      .busy       (busy),
      .route_done (route_done)
   );

   function automatic logic [11:0] polar(input int theta, input int r);
      return {5'(theta), 7'(r)};
   endfunction

   task automatic model_clk();
      logic [11:0] view [8];
      logic [11:0] old_loc;
      old_loc = m_loc;
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) m_tbl[i] = polar(6, 24);
         m_tbl[1] = polar(1, 32);
         m_tbl[2] = polar(7, 48);
         m_tbl[3] = polar(8, 10);
         m_tbl[4] = polar(11, 80);
         m_loc = polar(6, 24);
         m_idx = 0; m_len = 0; m_run = 0; m_done = 0; m_nt = 0;
         return;
      end
      view = m_tbl;
      if (wr_en) view[wr_addr] = wr_data;
      if (!mode) begin
         m_run = 0; m_done = 0;
         m_idx = int'(sel);
         m_loc = view[m_idx];
      end else if (m_run) begin
         if (arrived) begin
            if (m_idx == m_len - 1) begin m_run = 0; m_done = 1; end
            else m_idx = m_idx + 1;
         end
         m_loc = view[m_idx];
      end else if (start && route_len != 0) begin
         m_len = (int'(route_len) > 8) ? 8 : int'(route_len);
         m_idx = 0; m_run = 1; m_done = 0;
         m_loc = view[0];
      end else if (m_done) begin
         m_loc = view[m_idx];
      end
      m_nt = (m_loc != old_loc);
      if (wr_en) m_tbl[wr_addr] = wr_data;
   endtask

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      check("location",   location,          m_loc);
      check("cur_index",  12'(cur_index),    12'(m_idx));
      check("new_target", 12'(new_target),   12'(m_nt));
      check("busy",       12'(busy),         12'(m_run));
      check("route_done", 12'(route_done),   12'(m_done));
   endtask

   // One clock: model advances on the same inputs, outputs sampled 1ns after the edge,
   // then the one-cycle pulses are cleared.
   task automatic step();
      model_clk();
      @(posedge clock);
      #1;
      check_model();
      start = 1'b0; arrived = 1'b0; wr_en = 1'b0;
   endtask

   initial begin
      // reset
      repeat (3) step();
      check("rst_location", location, 12'h318);
      reset_n = 1'b1; mode = 1'b0; sel = 3'd0;
      step();
      check("rel_location", location, 12'h318);
      check("rel_new_target", 12'(new_target), 12'h0);
      check("rel_busy", 12'(busy), 12'h0);

      // manual select
      sel = 3'd4; step();
      check("man4_location", location, 12'h5D0);
      check("man4_new_target", 12'(new_target), 12'h1);
      step();
      check("man4_pulse_width", 12'(new_target), 12'h0);
      sel = 3'd3; step();
      check("man3_location", location, 12'h40A);

      // three-entry route
      mode = 1'b1; route_len = 4'd3; start = 1'b1; step();
      check("route_start_loc", location, 12'h318);
      check("route_start_busy", 12'(busy), 12'h1);
      step();
      arrived = 1'b1; step();
      check("route_arr1", location, 12'h0A0);
      arrived = 1'b1; step();
      check("route_arr2", location, 12'h3B0);
      arrived = 1'b1; step();
      check("route_done", 12'(route_done), 12'h1);
      check("route_done_loc", location, 12'h3B0);
      arrived = 1'b1; step();
      check("done_ignore_arr", location, 12'h3B0);

      // zero-length start stays idle
      mode = 1'b0; step();
      mode = 1'b1; step();
      route_len = 4'd0; start = 1'b1; step();
      check("len0_busy", 12'(busy), 12'h0);

      // oversize length clamps to the table depth
      route_len = 4'd12; start = 1'b1; step();
      for (int k = 0; k < 8; k++) begin
         arrived = 1'b1; step();
         if (k == 6) check("len12_busy_after7", 12'(busy), 12'h1);
      end
      check("len12_done", 12'(route_done), 12'h1);
      check("len12_index", 12'(cur_index), 12'h7);

      // start coinciding with arrived inside RUN only advances
      route_len = 4'd5; start = 1'b1; step();
      arrived = 1'b1; step();
      start = 1'b1; arrived = 1'b1; step();
      check("start_arr_index", 12'(cur_index), 12'h2);
      check("start_arr_busy", 12'(busy), 12'h1);

      // live edit of the current waypoint
      mode = 1'b0; step();
      mode = 1'b1; route_len = 4'd5; start = 1'b1; step();
      arrived = 1'b1; step();
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 12'h2FF; step();
      check("edit_loc", location, 12'h2FF);
      check("edit_new_target", 12'(new_target), 12'h1);
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 12'h123; step();
      check("edit_other_loc", location, 12'h2FF);

      // abort to manual mid-route
      arrived = 1'b1; step();
      mode = 1'b0; sel = 3'd6; step();
      check("abort_busy", 12'(busy), 12'h0);
      check("abort_loc", location, 12'h318);

      // reset mid-route restores the table image
      mode = 1'b1; route_len = 4'd4; start = 1'b1; step();
      arrived = 1'b1; step();
      arrived = 1'b1; step();
      reset_n = 1'b0; step();
      check("midrst_loc", location, 12'h318);
      check("midrst_busy", 12'(busy), 12'h0);
      reset_n = 1'b1; mode = 1'b0; sel = 3'd1; step();
      check("restored_e1", location, 12'h0A0);
      sel = 3'd5; step();
      check("restored_e5", location, 12'h318);

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         reset_n   = ($urandom_range(99) != 0);
         mode      = ($urandom_range(7) != 0);
         sel       = 3'($urandom);
         route_len = 4'($urandom);
         start     = ($urandom_range(7) == 0);
         arrived   = ($urandom_range(2) == 0);
         wr_en     = ((!mode || m_run) && ($urandom_range(5) == 0));
         wr_addr   = 3'($urandom);
         wr_data   = 12'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
